wired_rob: RTL and testbench
============================

WIRED_ROB -- requirements
Module: wired_rob

Interface
REQ-001 The block SHALL have parameter ROB_LEN, default `_WIRED_PARAM_ROB_LEN, meaning log2 of entry count (DEPTH = 2^ROB_LEN).
REQ-002 The block SHALL have port clk, input, 1, the single clock.
REQ-003 The block SHALL have port rst_n, input, 1, reset (asynchronous, active-low).
REQ-004 The block SHALL have port p_valid_i, input, 2, dispatch allocate request per slot; must be prefix form 00/01/11.
REQ-005 The block SHALL have port p_entry_i, input, 2 x rob_entry_t, static info per dispatched instruction.
REQ-006 The block SHALL have port p_ready_o, output, 1, space available for two allocations.
REQ-007 The block SHALL have port p_rid_o, output, 2 x rob_rid_t, allocated ids (tail, tail+1).
REQ-008 The block SHALL have port cdb_valid_i, input, 2, writeback valid per CDB lane.
REQ-009 The block SHALL have port cdb_i, input, 2 x rob_cdb_t, writeback {rid, data, exception info}.
REQ-010 The block SHALL have port c_rrrid_i, input, 2 x rob_rid_t, commit read ids (head, head+1).
REQ-011 The block SHALL have port c_rob_valid_o, output, 2, entry allocated and written back.
REQ-012 The block SHALL have port c_rob_entry_o, output, 2 x rob_entry_t, merged static+dynamic entry.
REQ-013 The block SHALL have port c_retire_i, input, 2, retire pop, prefix form 00/01/11.
REQ-014 The block SHALL have port flush_i, input, 1, discard all entries.

Function
REQ-015 The block SHALL hold head_q, tail_q (ROB_LEN bits, natural wrap) and cnt_q (ROB_LEN+1 bits).
REQ-016 p_ready_o SHALL be 1 exactly when DEPTH - cnt_q >= 2 (combinational from registers only, not from c_retire_i).
REQ-017 Allocation SHALL occur when p_ready_o & p_valid_i[k]: entry tail_q+k written with p_entry_i[k], done bit cleared; tail_q advances by popcount(p_valid_i & {2{p_ready_o}}).
REQ-018 A CDB lane SHALL set done and store dynamic fields of entry cdb_i[k].rid at the clock edge; both lanes to distinct rids in one cycle SHALL both take effect.
REQ-019 Two CDB lanes targeting the same rid SHALL be flagged by an assertion; lane 1 wins.
REQ-020 A CDB write to an unallocated rid SHALL be flagged by assertion and SHALL NOT alter done bits of allocated entries.
REQ-021 Commit read SHALL be combinational from c_rrrid_i; c_rob_valid_o[k] = done(rid) & (rid - head_q) < cnt_q.
REQ-022 A CDB write in cycle N SHALL be visible on the commit port in cycle N+1, not N (no bypass).
REQ-023 Retire SHALL advance head_q by popcount(c_retire_i) and clear done bits of retired entries; c_retire_i[k] without c_rob_valid_o[k] SHALL be flagged by assertion.
REQ-024 Simultaneous allocate and retire SHALL update cnt_q by alloc - retire in one cycle; full-to-nonfull frees are seen by p_ready_o next cycle.
REQ-025 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, including allocate/retire pairs straddling the wrap.
REQ-026 flush_i SHALL have priority over allocate, CDB and retire in the same cycle: next state head_q=tail_q=0, cnt_q=0, all done bits 0.
REQ-027 Payload storage SHALL NOT require reset; only control state (pointers, count, done bits) is reset.

Reset
REQ-028 On rst_n low (asynchronous), head_q=0, tail_q=0, cnt_q=0, all done bits 0; hence p_ready_o=1, p_rid_o={1,0}, c_rob_valid_o=00.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight entries identically to flush; release is synchronous to clk.

Structure
REQ-030 rob_entry_t, rob_cdb_t, rob_rid_t, word_t and `_WIRED_PARAM_ROB_LEN SHALL live in the shared wired0_defines package.
REQ-031 Payload storage SHALL be a sub-module wired_rob_ram: 2 write ports for dispatch, 2 for CDB dynamic fields, 2 combinational read ports; no reset.

Verification
REQ-032 Reset then dispatch 11 with DEPTH=64 -> p_rid_o={1,0}, cnt=2 next cycle, c_rob_valid_o=00 until CDB.
REQ-033 Alloc rid 0,1; CDB rid1 in cycle N, rid0 in N+1 -> c_rob_valid_o=10 at N+1, 11 at N+2; retire 11 -> cnt=0.
REQ-034 Fill to cnt=62 -> p_ready_o=1; fill to 63 -> p_ready_o=0; retire 01 with dispatch 00 -> p_ready_o=1 next cycle.
REQ-035 head=tail=63, dispatch 11 -> rids {0,63}; CDB both, retire 11 -> head=1, cnt=0.
REQ-036 cnt=10, flush_i with dispatch 11, CDB and retire 01 same cycle -> head=tail=cnt=0, all done=0 next cycle.
REQ-037 rst_n asserted asynchronously mid-cycle with cnt=5 -> outputs at reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/wired_rob_pkg.sv
// Shared wired0 types for the reorder buffer: ids, static/dynamic entry halves, writeback bus.
`ifndef WIRED0_DEFINES_SV
`define WIRED0_DEFINES_SV
`define _WIRED_PARAM_ROB_LEN 6

package wired0_defines;
  localparam int NUM_LANES   = 2;
  localparam int ROB_LEN_DEF = `_WIRED_PARAM_ROB_LEN;

  typedef logic [31:0]            word_t;
  typedef logic [ROB_LEN_DEF-1:0] rob_rid_t;

  // Written once at dispatch.
  typedef struct packed {
    word_t       pc;
    logic [4:0]  rd;
    logic        rd_we;
    logic [3:0]  fu;
  } rob_static_t;

  // Written by the CDB at writeback.
  typedef struct packed {
    word_t       data;
    logic        exc;
    logic [4:0]  ecode;
  } rob_dyn_t;

  typedef struct packed {
    rob_static_t st;
    rob_dyn_t    dyn;
  } rob_entry_t;

  typedef struct packed {
    rob_rid_t    rid;
    rob_dyn_t    dyn;
  } rob_cdb_t;

  function automatic logic [1:0] pop2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction
endpackage

`endif

// File: rtl/wired_rob_ram.sv
// ROB payload store: static half from dispatch, dynamic half from the CDB, async read.
module wired_rob_ram
  import wired0_defines::*;
#(
  parameter int ROB_LEN = `_WIRED_PARAM_ROB_LEN
) (
  input  logic                                  clk,
  input  logic        [NUM_LANES-1:0]           st_we,
  input  logic        [NUM_LANES-1:0][ROB_LEN-1:0] st_waddr,
  input  rob_static_t [NUM_LANES-1:0]           st_wdata,
  input  logic        [NUM_LANES-1:0]           dyn_we,
  input  logic        [NUM_LANES-1:0][ROB_LEN-1:0] dyn_waddr,
  input  rob_dyn_t    [NUM_LANES-1:0]           dyn_wdata,
  input  logic        [NUM_LANES-1:0][ROB_LEN-1:0] raddr,
  output rob_entry_t  [NUM_LANES-1:0]           rdata
);
  localparam int DEPTH = 1 << ROB_LEN;

  rob_static_t st_mem  [DEPTH];
  rob_dyn_t    dyn_mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_LANES; k++)
      if (st_we[k]) st_mem[st_waddr[k]] <= st_wdata[k];
  end

  // Higher lane is written last so it wins on a same-address collision.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_LANES; k++)
      if (dyn_we[k]) dyn_mem[dyn_waddr[k]] <= dyn_wdata[k];
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_rd
    assign rdata[k] = {st_mem[raddr[k]], dyn_mem[raddr[k]]};
  end
endmodule

// File: rtl/wired_rob.sv
// Two-wide reorder buffer: in-order allocate/retire ring with out-of-order CDB writeback.
module wired_rob
  import wired0_defines::*;
#(
  parameter int ROB_LEN = `_WIRED_PARAM_ROB_LEN
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic       [NUM_LANES-1:0]  p_valid_i,
  input  rob_entry_t [NUM_LANES-1:0]  p_entry_i,
  output logic                        p_ready_o,
  output rob_rid_t   [NUM_LANES-1:0]  p_rid_o,
  input  logic       [NUM_LANES-1:0]  cdb_valid_i,
  input  rob_cdb_t   [NUM_LANES-1:0]  cdb_i,
  input  rob_rid_t   [NUM_LANES-1:0]  c_rrrid_i,
  output logic       [NUM_LANES-1:0]  c_rob_valid_o,
  output rob_entry_t [NUM_LANES-1:0]  c_rob_entry_o,
  input  logic       [NUM_LANES-1:0]  c_retire_i,
  input  logic                        flush_i
);
  localparam int DEPTH = 1 << ROB_LEN;

  typedef logic [ROB_LEN-1:0] ptr_t;
  typedef logic [ROB_LEN:0]   cnt_t;

  ptr_t                         head_q, tail_q;
  cnt_t                         cnt_q;
  logic [DEPTH-1:0]             done_q, done_d;
  logic [NUM_LANES-1:0]         alloc, cdb_live;
  cnt_t                         n_alloc, n_ret;
  ptr_t [NUM_LANES-1:0]         alloc_ptr, ret_ptr, cdb_ptr, rd_ptr;
  rob_static_t [NUM_LANES-1:0]  alloc_st;
  rob_dyn_t    [NUM_LANES-1:0]  cdb_dyn;
  logic                         unused_disp_dyn;

  assign p_ready_o = (cnt_q <= cnt_t'(DEPTH - 2));
  assign alloc     = p_valid_i & {NUM_LANES{p_ready_o}};
  assign n_alloc   = cnt_t'(pop2(alloc));
  assign n_ret     = cnt_t'(pop2(c_retire_i));

  // Dispatch carries no dynamic fields; those only arrive on the CDB.
  assign unused_disp_dyn = ^{p_entry_i[0].dyn, p_entry_i[1].dyn};

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign alloc_ptr[k] = tail_q + ptr_t'(k);
    assign ret_ptr[k]   = head_q + ptr_t'(k);
    assign cdb_ptr[k]   = ptr_t'(cdb_i[k].rid);
    assign rd_ptr[k]    = ptr_t'(c_rrrid_i[k]);
    assign alloc_st[k]  = p_entry_i[k].st;
    assign cdb_dyn[k]   = cdb_i[k].dyn;
    assign p_rid_o[k]   = rob_rid_t'(alloc_ptr[k]);

    // An id is live when its distance from head is inside the occupied window.
    assign cdb_live[k]      = cdb_valid_i[k] & ({1'b0, ptr_t'(cdb_ptr[k] - head_q)} < cnt_q);
    assign c_rob_valid_o[k] = done_q[rd_ptr[k]] & ({1'b0, ptr_t'(rd_ptr[k] - head_q)} < cnt_q);

    a_cdb_live: assert property (@(posedge clk) disable iff (!rst_n)
      cdb_valid_i[k] |-> cdb_live[k]);
    a_retire_ok: assert property (@(posedge clk) disable iff (!rst_n)
      c_retire_i[k] |-> c_rob_valid_o[k]);
  end

  a_cdb_same_rid: assert property (@(posedge clk) disable iff (!rst_n)
    !(&cdb_valid_i && (cdb_ptr[0] == cdb_ptr[1])));
  a_p_prefix: assert property (@(posedge clk) disable iff (!rst_n) p_valid_i != 2'b10);
  a_retire_prefix: assert property (@(posedge clk) disable iff (!rst_n) c_retire_i != 2'b10);

  // Alloc/CDB/retire slots never overlap in legal use: alloc targets free slots,
  // CDB only live ones, retire only done ones.
  always_comb begin
    done_d = done_q;
    for (int k = 0; k < NUM_LANES; k++)
      if (alloc[k]) done_d[alloc_ptr[k]] = 1'b0;
    for (int k = 0; k < NUM_LANES; k++)
      if (cdb_live[k]) done_d[cdb_ptr[k]] = 1'b1;
    for (int k = 0; k < NUM_LANES; k++)
      if (c_retire_i[k]) done_d[ret_ptr[k]] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      done_q <= '0;
    end else if (flush_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      done_q <= '0;
    end else begin
      head_q <= head_q + ptr_t'(n_ret);
      tail_q <= tail_q + ptr_t'(n_alloc);
      cnt_q  <= cnt_q + n_alloc - n_ret;
      done_q <= done_d;
    end
  end

  wired_rob_ram #(.ROB_LEN(ROB_LEN)) u_ram (
    .clk      (clk),
    .st_we    (alloc),
    .st_waddr (alloc_ptr),
    .st_wdata (alloc_st),
    .dyn_we   (cdb_live),
    .dyn_waddr(cdb_ptr),
    .dyn_wdata(cdb_dyn),
    .raddr    (rd_ptr),
    .rdata    (c_rob_entry_o)
  );
endmodule

// File: tb/tb_wired_rob.sv
// Scenario bench for wired_rob: dispatch pushes expected entries, retire pops and compares.
module tb_wired_rob;
  import wired0_defines::*;

  localparam int DEPTH = 64;

  typedef struct {
    int          rid;
    rob_static_t st;
  } sb_t;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic       [1:0]            p_valid_i;
  rob_entry_t [1:0]            p_entry_i;
  logic                        p_ready_o;
  rob_rid_t   [1:0]            p_rid_o;
  logic       [1:0]            cdb_valid_i;
  rob_cdb_t   [1:0]            cdb_i;
  rob_rid_t   [1:0]            c_rrrid_i;
  logic       [1:0]            c_rob_valid_o;
  rob_entry_t [1:0]            c_rob_entry_o;
  logic       [1:0]            c_retire_i;
  logic                        flush_i;

  int checks = 0;
  int errors = 0;

  int               m_head, m_tail, m_cnt;
  logic [DEPTH-1:0] m_done;
  rob_dyn_t         m_dyn [DEPTH];
  sb_t              sb_q [$];

  always #5 clk = ~clk;

  wired_rob dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .p_valid_i    (p_valid_i),
    .p_entry_i    (p_entry_i),
    .p_ready_o    (p_ready_o),
    .p_rid_o      (p_rid_o),
    .cdb_valid_i  (cdb_valid_i),
    .cdb_i        (cdb_i),
    .c_rrrid_i    (c_rrrid_i),
    .c_rob_valid_o(c_rob_valid_o),
    .c_rob_entry_o(c_rob_entry_o),
    .c_retire_i   (c_retire_i),
    .flush_i      (flush_i)
  );

  function automatic rob_dyn_t rand_dyn();
    rob_dyn_t d;
    d.data  = $urandom;
    d.exc   = 1'($urandom);
    d.ecode = 5'($urandom);
    return d;
  endfunction

  function automatic rob_entry_t rand_entry();
    rob_entry_t e;
    e.st.pc    = $urandom;
    e.st.rd    = 5'($urandom);
    e.st.rd_we = 1'($urandom);
    e.st.fu    = 4'($urandom);
    e.dyn      = rand_dyn();
    return e;
  endfunction

  task automatic model_reset();
    m_head = 0; m_tail = 0; m_cnt = 0; m_done = '0;
    sb_q.delete();
  endtask

  // Apply one cycle of inputs; commit reads always point at the model head.
  task automatic drive(input logic [1:0] pv, input logic [1:0] cv, input int r0, input int r1,
                       input logic [1:0] ret, input logic fl);
    p_valid_i      = pv;
    p_entry_i[0]   = rand_entry();
    p_entry_i[1]   = rand_entry();
    cdb_valid_i    = cv;
    cdb_i[0].rid   = rob_rid_t'(r0);
    cdb_i[0].dyn   = rand_dyn();
    cdb_i[1].rid   = rob_rid_t'(r1);
    cdb_i[1].dyn   = rand_dyn();
    c_rrrid_i[0]   = rob_rid_t'(m_head);
    c_rrrid_i[1]   = rob_rid_t'(m_head + 1);
    c_retire_i     = ret;
    flush_i        = fl;
    #1;
  endtask

  // Advance the reference model with the applied inputs, then cross the clock edge.
  task automatic tick();
    logic rdy;
    int   na, nr;
    sb_t  tmp;
    rdy = (m_cnt <= DEPTH - 2);
    if (flush_i) begin
      model_reset();
    end else begin
      na = 0; nr = 0;
      for (int k = 0; k < 2; k++)
        if (p_valid_i[k] && rdy) begin
          sb_q.push_back('{rid: (m_tail + k) % DEPTH, st: p_entry_i[k].st});
          m_done[(m_tail + k) % DEPTH] = 1'b0;
          na++;
        end
      for (int k = 0; k < 2; k++)
        if (cdb_valid_i[k]) begin
          m_dyn[cdb_i[k].rid]  = cdb_i[k].dyn;
          m_done[cdb_i[k].rid] = 1'b1;
        end
      for (int k = 0; k < 2; k++)
        if (c_retire_i[k]) begin
          tmp = sb_q.pop_front();
          m_done[(m_head + k) % DEPTH] = 1'b0;
          nr++;
        end
      m_tail = (m_tail + na) % DEPTH;
      m_head = (m_head + nr) % DEPTH;
      m_cnt  = m_cnt + na - nr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
    checks++;
    if (p_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", p_ready_o); end
    checks++;
    if (p_rid_o[1] !== 6'd1 || p_rid_o[0] !== 6'd0) begin
      errors++; $display("FAIL reset_rid: got {%0d,%0d} expected {1,0}", p_rid_o[1], p_rid_o[0]);
    end
    checks++;
    if (c_rob_valid_o !== 2'b00) begin errors++; $display("FAIL reset_cvalid: got %b expected 00", c_rob_valid_o); end
    checks++;
    if (dut.cnt_q !== 7'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", dut.cnt_q); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_dispatch();
    drive(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
    checks++;
    if (p_rid_o[1] !== 6'd1 || p_rid_o[0] !== 6'd0) begin
      errors++; $display("FAIL disp_rid: got {%0d,%0d} expected {1,0}", p_rid_o[1], p_rid_o[0]);
    end
    tick();
    checks++;
    if (dut.cnt_q !== 7'd2) begin errors++; $display("FAIL disp_cnt: got %0d expected 2", dut.cnt_q); end
    checks++;
    if (p_rid_o[0] !== 6'd2) begin errors++; $display("FAIL disp_tail: got %0d expected 2", p_rid_o[0]); end
    drive(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
    checks++;
    if (c_rob_valid_o !== 2'b00) begin errors++; $display("FAIL disp_cvalid: got %b expected 00", c_rob_valid_o); end
    tick();
  endtask

  task automatic test_cdb_order();
    rob_entry_t exp_e;
    drive(2'b00, 2'b01, 1, 0, 2'b00, 1'b0);
    checks++;
    if (c_rob_valid_o !== 2'b00) begin errors++; $display("FAIL cdb_nobypass: got %b expected 00", c_rob_valid_o); end
    tick();
    drive(2'b00, 2'b01, 0, 0, 2'b00, 1'b0);
    checks++;
    if (c_rob_valid_o !== 2'b10) begin errors++; $display("FAIL cdb_n1: got %b expected 10", c_rob_valid_o); end
    tick();
    drive(2'b00, 2'b00, 0, 0, 2'b11, 1'b0);
    checks++;
    if (c_rob_valid_o !== 2'b11) begin errors++; $display("FAIL cdb_n2: got %b expected 11", c_rob_valid_o); end
    for (int k = 0; k < 2; k++)
      if (c_retire_i[k]) begin
        exp_e = {sb_q[k].st, m_dyn[sb_q[k].rid]};
        checks++;
        if (c_rob_entry_o[k] !== exp_e) begin
          errors++; $display("FAIL cdb_entry lane%0d: got %h expected %h", k, c_rob_entry_o[k], exp_e);
        end
      end
    tick();
    checks++;
    if (dut.cnt_q !== 7'd0 || dut.head_q !== 6'd2) begin
      errors++; $display("FAIL cdb_retire: got cnt=%0d head=%0d expected cnt=0 head=2", dut.cnt_q, dut.head_q);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 31; i++) begin
      drive(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
      tick();
    end
    checks++;
    if (p_ready_o !== 1'b1 || dut.cnt_q !== 7'd62) begin
      errors++; $display("FAIL full_62: got ready=%b cnt=%0d expected ready=1 cnt=62", p_ready_o, dut.cnt_q);
    end
    drive(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);
    tick();
    checks++;
    if (p_ready_o !== 1'b0 || dut.cnt_q !== 7'd63) begin
      errors++; $display("FAIL full_63: got ready=%b cnt=%0d expected ready=0 cnt=63", p_ready_o, dut.cnt_q);
    end
    drive(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
    tick();
    checks++;
    if (dut.cnt_q !== 7'd63 || p_rid_o[0] !== 6'd1) begin
      errors++; $display("FAIL full_ignore: got cnt=%0d tail=%0d expected cnt=63 tail=1", dut.cnt_q, p_rid_o[0]);
    end
    drive(2'b00, 2'b01, 2, 0, 2'b00, 1'b0);
    tick();
    drive(2'b00, 2'b00, 0, 0, 2'b01, 1'b0);
    checks++;
    if (p_ready_o !== 1'b0) begin errors++; $display("FAIL full_retire_same: got %b expected 0", p_ready_o); end
    tick();
    checks++;
    if (p_ready_o !== 1'b1 || dut.cnt_q !== 7'd62) begin
      errors++; $display("FAIL full_freed: got ready=%b cnt=%0d expected ready=1 cnt=62", p_ready_o, dut.cnt_q);
    end
  endtask

  task automatic test_flush();
    drive(2'b00, 2'b00, 0, 0, 2'b00, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(2'b11, (i > 0) ? 2'b11 : 2'b00, 2 * (i - 1), 2 * (i - 1) + 1, 2'b00, 1'b0);
      tick();
    end
    drive(2'b11, 2'b11, 8, 9, 2'b01, 1'b1);
    checks++;
    if (dut.cnt_q !== 7'd10 || c_rob_valid_o !== 2'b11) begin
      errors++; $display("FAIL flush_pre: got cnt=%0d cvalid=%b expected cnt=10 cvalid=11", dut.cnt_q, c_rob_valid_o);
    end
    tick();
    checks++;
    if (dut.head_q !== 6'd0 || dut.tail_q !== 6'd0 || dut.cnt_q !== 7'd0) begin
      errors++; $display("FAIL flush_ptrs: got head=%0d tail=%0d cnt=%0d expected 0 0 0", dut.head_q, dut.tail_q, dut.cnt_q);
    end
    checks++;
    if (dut.done_q !== 64'd0) begin errors++; $display("FAIL flush_done: got %h expected 0", dut.done_q); end
    checks++;
    if (p_ready_o !== 1'b1 || p_rid_o[1] !== 6'd1 || p_rid_o[0] !== 6'd0 || c_rob_valid_o !== 2'b00) begin
      errors++; $display("FAIL flush_outs: got ready=%b rid={%0d,%0d} cvalid=%b expected 1 {1,0} 00",
                         p_ready_o, p_rid_o[1], p_rid_o[0], c_rob_valid_o);
    end
  endtask

  task automatic test_wrap();
    rob_entry_t exp_e;
    for (int i = 0; i <= 64; i++) begin
      drive((i < 63) ? 2'b01 : 2'b00, (i >= 1 && i <= 63) ? 2'b01 : 2'b00, i - 1, 0,
            (i >= 2) ? 2'b01 : 2'b00, 1'b0);
      if (c_retire_i[0]) begin
        exp_e = {sb_q[0].st, m_dyn[sb_q[0].rid]};
        checks++;
        if (c_rob_valid_o[0] !== 1'b1 || c_rob_entry_o[0] !== exp_e) begin
          errors++; $display("FAIL wrap_stream rid%0d: got v=%b %h expected v=1 %h",
                             sb_q[0].rid, c_rob_valid_o[0], c_rob_entry_o[0], exp_e);
        end
      end
      tick();
    end
    checks++;
    if (dut.head_q !== 6'd63 || dut.tail_q !== 6'd63 || dut.cnt_q !== 7'd0) begin
      errors++; $display("FAIL wrap_setup: got head=%0d tail=%0d cnt=%0d expected 63 63 0", dut.head_q, dut.tail_q, dut.cnt_q);
    end
    drive(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
    checks++;
    if (p_rid_o[1] !== 6'd0 || p_rid_o[0] !== 6'd63) begin
      errors++; $display("FAIL wrap_rid: got {%0d,%0d} expected {0,63}", p_rid_o[1], p_rid_o[0]);
    end
    tick();
    drive(2'b00, 2'b11, 63, 0, 2'b00, 1'b0);
    tick();
    drive(2'b00, 2'b00, 0, 0, 2'b11, 1'b0);
    checks++;
    if (c_rob_valid_o !== 2'b11) begin errors++; $display("FAIL wrap_cvalid: got %b expected 11", c_rob_valid_o); end
    for (int k = 0; k < 2; k++) begin
      exp_e = {sb_q[k].st, m_dyn[sb_q[k].rid]};
      checks++;
      if (c_rob_entry_o[k] !== exp_e) begin
        errors++; $display("FAIL wrap_entry lane%0d: got %h expected %h", k, c_rob_entry_o[k], exp_e);
      end
    end
    tick();
    checks++;
    if (dut.head_q !== 6'd1 || dut.cnt_q !== 7'd0) begin
      errors++; $display("FAIL wrap_final: got head=%0d cnt=%0d expected head=1 cnt=0", dut.head_q, dut.cnt_q);
    end
  endtask

  task automatic test_back_to_back();
    rob_entry_t exp_e;
    logic [1:0] pv, cv, ret, exp_v;
    int         r0, r1, a, b;
    int         cand [$];
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 2))
        0:       pv = 2'b00;
        1:       pv = 2'b01;
        default: pv = 2'b11;
      endcase
      cand.delete();
      foreach (sb_q[i]) if (!m_done[sb_q[i].rid]) cand.push_back(sb_q[i].rid);
      cv = 2'b00; r0 = 0; r1 = 0;
      if (cand.size() > 0 && $urandom_range(0, 3) != 0) begin
        a = $urandom_range(0, cand.size() - 1);
        cv[0] = 1'b1; r0 = cand[a];
        if (cand.size() > 1 && $urandom_range(0, 1) == 1) begin
          b = (a + 1 + $urandom_range(0, cand.size() - 2)) % cand.size();
          cv[1] = 1'b1; r1 = cand[b];
        end
      end
      ret[0] = (m_cnt > 0) && m_done[m_head] && ($urandom_range(0, 3) != 0);
      ret[1] = ret[0] && (m_cnt > 1) && m_done[(m_head + 1) % DEPTH] && ($urandom_range(0, 3) != 0);
      exp_v[0] = (m_cnt > 0) && m_done[m_head];
      exp_v[1] = (m_cnt > 1) && m_done[(m_head + 1) % DEPTH];
      drive(pv, cv, r0, r1, ret, 1'b0);
      checks++;
      if (p_ready_o !== (m_cnt <= DEPTH - 2) || p_rid_o[0] !== rob_rid_t'(m_tail)) begin
        errors++; $display("FAIL b2b_alloc cyc%0d: got ready=%b rid=%0d expected cnt=%0d tail=%0d",
                           n, p_ready_o, p_rid_o[0], m_cnt, m_tail);
      end
      checks++;
      if (c_rob_valid_o !== exp_v) begin
        errors++; $display("FAIL b2b_cvalid cyc%0d: got %b expected %b", n, c_rob_valid_o, exp_v);
      end
      for (int k = 0; k < 2; k++)
        if (c_retire_i[k]) begin
          exp_e = {sb_q[k].st, m_dyn[sb_q[k].rid]};
          checks++;
          if (c_rob_entry_o[k] !== exp_e) begin
            errors++; $display("FAIL b2b_entry cyc%0d lane%0d: got %h expected %h", n, k, c_rob_entry_o[k], exp_e);
          end
        end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(2'b00, 2'b00, 0, 0, 2'b00, 1'b1);
    tick();
    drive(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
    tick();
    drive(2'b11, 2'b11, 0, 1, 2'b00, 1'b0);
    tick();
    drive(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);
    tick();
    drive(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
    checks++;
    if (dut.cnt_q !== 7'd5 || c_rob_valid_o !== 2'b11) begin
      errors++; $display("FAIL areset_pre: got cnt=%0d cvalid=%b expected cnt=5 cvalid=11", dut.cnt_q, c_rob_valid_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (p_ready_o !== 1'b1 || p_rid_o[1] !== 6'd1 || p_rid_o[0] !== 6'd0 || c_rob_valid_o !== 2'b00) begin
      errors++; $display("FAIL areset_outs: got ready=%b rid={%0d,%0d} cvalid=%b expected 1 {1,0} 00",
                         p_ready_o, p_rid_o[1], p_rid_o[0], c_rob_valid_o);
    end
    checks++;
    if (dut.cnt_q !== 7'd0) begin errors++; $display("FAIL areset_cnt: got %0d expected 0", dut.cnt_q); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
    tick();
    checks++;
    if (dut.cnt_q !== 7'd2 || p_rid_o[0] !== 6'd2) begin
      errors++; $display("FAIL areset_resume: got cnt=%0d tail=%0d expected cnt=2 tail=2", dut.cnt_q, p_rid_o[0]);
    end
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_cdb_order();
    test_full();
    test_flush();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1);
  end
endmodule
